// File: rtl/axi_aw_before_w_pkg.sv
// axi_aw_before_w_pkg: shared AXI types for the AW-before-W ordering stage.
// Provides len_t and compact AXI request/response bundles used as defaults.
package axi_aw_before_w_pkg;

    typedef logic [7:0] len_t;

    localparam int unsigned IdW   = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 32;
    localparam int unsigned StrbW = DataW / 8;

    typedef logic [IdW-1:0]   id_t;
    typedef logic [AddrW-1:0] addr_t;
    typedef logic [DataW-1:0] data_t;
    typedef logic [StrbW-1:0] strb_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        len_t       len;
        logic [2:0] size;
        logic [1:0] burst;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        logic  user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        id_t   id;
        addr_t addr;
        len_t  len;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

endpackage

// File: rtl/axi_aw_before_w_fifo.sv
// axi_aw_before_w_fifo: small ring-buffer FIFO holding outstanding burst lengths.
// Ports: clk_i/rst_ni, flush_i, full_o/empty_o, push_i+data_i, pop_i+data_o.
module axi_aw_before_w_fifo
    import axi_aw_before_w_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 4,
    parameter type         dtype        = len_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    dtype            mem [DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] cnt;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        full_o  = (cnt == CntW'(DEPTH));
        empty_o = (cnt == '0);
        data_o  = mem[rd_ptr];
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        // Fall-through bypasses storage when the entry is consumed at once.
        if (FALL_THROUGH && empty_o && push_i) begin
            data_o  = data_i;
            empty_o = 1'b0;
            if (pop_i) begin
                do_push = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CntW'(1);
            end else if (!do_push && do_pop) begin
                cnt <= cnt - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

`ifndef SYNTHESIS
    depth_a: assert property (@(posedge clk_i) DEPTH >= 1);
    push_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o));
    pop_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && empty_o));
`endif

endmodule

// File: rtl/axi_aw_before_w.sv
// axi_aw_before_w: holds W beats until their AW has handshaken downstream.
// Ports: clk_i/rst_ni, slv_req_i/slv_resp_o (upstream), mst_req_o/mst_resp_i, err_o.
module axi_aw_before_w
    import axi_aw_before_w_pkg::*;
#(
    parameter int unsigned MaxWTxns = 4,
    parameter type         req_t    = axi_req_t,
    parameter type         resp_t   = axi_resp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o,
    output req_t  mst_req_o,
    input  resp_t mst_resp_i,
    output logic  err_o
);

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic w_hs;
    logic gen_last;
    len_t head_len;
    len_t beat_cnt;
    logic err_q;

    // Full/empty gate both valid and ready so neither side sees a handshake
    // the other did not; they only change on handshakes that end a beat.
    assign push     = slv_req_i.aw_valid & mst_resp_i.aw_ready & ~full;
    assign w_hs     = slv_req_i.w_valid & mst_resp_i.w_ready & ~empty;
    assign gen_last = (beat_cnt == head_len);
    assign pop      = w_hs & gen_last;
    assign err_o    = err_q;

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid & ~full;
        mst_req_o.w_valid  = slv_req_i.w_valid & ~empty;
        mst_req_o.w.last   = gen_last;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~full;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & ~empty;
    end

    axi_aw_before_w_fifo #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (MaxWTxns),
        .dtype        (len_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (full),
        .empty_o (empty),
        .data_i  (slv_req_i.aw.len),
        .push_i  (push),
        .data_o  (head_len),
        .pop_i   (pop)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt <= '0;
        end else if (w_hs) begin
            beat_cnt <= gen_last ? '0 : beat_cnt + len_t'(1);
        end
    end

    // Upstream last is only cross-checked; the generated last is forwarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (w_hs && (slv_req_i.w.last != gen_last)) begin
            err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    txns_a: assert property (@(posedge clk_i) MaxWTxns >= 1);
`endif

endmodule

// File: tb/tb_axi_aw_before_w.sv
module tb_axi_aw_before_w;
    import axi_aw_before_w_pkg::*;

    localparam int NBursts = 200;
    localparam int MaxCyc  = 40000;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        int          burst;
    } wexp_t;

    logic      clk = 1'b0;
    logic      rst_n;
    axi_req_t  slv_req;
    axi_resp_t slv_resp;
    axi_req_t  mst_req;
    axi_resp_t mst_resp;
    logic      err;

    int checks   = 0;
    int failures = 0;

    aw_chan_t   plan [NBursts];
    aw_chan_t   exp_aw [$];
    wexp_t      exp_w [$];
    logic [3:0] exp_b [$];
    logic       mon_on = 1'b0;
    int         aw_hs_seen = 0;

    always #5 clk = ~clk;

    axi_aw_before_w #(
        .MaxWTxns (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
        .err_o      (err)
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT shows a handshake.
    initial begin : monitor
        wexp_t    e;
        aw_chan_t a;
        forever begin
            @(negedge clk);
            if (mon_on && rst_n) begin
                if (mst_req.w_valid && mst_resp.w_ready) begin
                    if (exp_w.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL w_unexpected data=%h", mst_req.w.data);
                    end else begin
                        e = exp_w.pop_front();
                        chk("w_data", mst_req.w.data, e.data);
                        chk("w_strb", mst_req.w.strb, e.strb);
                        chk("w_last", mst_req.w.last, e.last);
                        chk("w_after_aw", 32'(e.burst < aw_hs_seen), 1);
                    end
                end
                if (mst_req.aw_valid && mst_resp.aw_ready) begin
                    if (exp_aw.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL aw_unexpected id=%h", mst_req.aw.id);
                    end else begin
                        a = exp_aw.pop_front();
                        chk("aw_id", mst_req.aw.id, a.id);
                        chk("aw_addr", mst_req.aw.addr, a.addr);
                        chk("aw_len", mst_req.aw.len, a.len);
                    end
                    aw_hs_seen++;
                end
                if (slv_resp.b_valid && slv_req.b_ready) begin
                    if (exp_b.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL b_unexpected id=%h", slv_resp.b.id);
                    end else begin
                        chk("b_id", slv_resp.b.id, exp_b.pop_front());
                    end
                end
            end
        end
    end

    initial begin : main
        int hs;
        int aw_i, w_k, w_b, b_got, cyc;
        logic s_aw, s_w, s_wl, s_maw, s_mwl, s_b;
        logic [3:0] s_maw_id;
        logic [3:0] s_ids [$];
        logic [3:0] s_bq [$];

        slv_req  = '0;
        mst_resp = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        slv_req.w_valid   = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        @(negedge clk);
        chk("rst_err", err, 0);
        chk("rst_mst_wv", mst_req.w_valid, 0);
        chk("rst_slv_wr", slv_resp.w_ready, 0);
        chk("rst_mst_awv", mst_req.aw_valid, 0);
        step();
        rst_n = 1'b1;
        slv_req.w_valid = 1'b0;

        // AR/R/B pass-through
        slv_req.ar_valid  = 1'b1;
        slv_req.ar.addr   = 32'h1234_5678;
        slv_req.r_ready   = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.r_valid  = 1'b1;
        mst_resp.r.data   = 32'h8765_4321;
        mst_resp.b_valid  = 1'b1;
        mst_resp.b.id     = 4'h5;
        #1;
        chk("ar_addr", mst_req.ar.addr, 32'h1234_5678);
        chk("ar_valid", mst_req.ar_valid, 1);
        chk("r_ready", mst_req.r_ready, 1);
        chk("ar_ready", slv_resp.ar_ready, 1);
        chk("r_data", slv_resp.r.data, 32'h8765_4321);
        chk("b_id_pt", slv_resp.b.id, 4'h5);
        slv_req.ar_valid  = 1'b0;
        slv_req.r_ready   = 1'b0;
        mst_resp.ar_ready = 1'b0;
        mst_resp.r_valid  = 1'b0;
        mst_resp.b_valid  = 1'b0;
        mst_resp.b.id     = '0;
        step();

        // single ordered burst, len=3
        slv_req.aw_valid = 1'b1;
        slv_req.aw.len   = 8'd3;
        slv_req.aw.id    = 4'h1;
        slv_req.w_valid  = 1'b1;
        slv_req.w.data   = 32'h1000;
        slv_req.w.last   = 1'b0;
        @(negedge clk);
        chk("t1_aw_fwd", mst_req.aw_valid, 1);
        chk("t1_w_blocked", mst_req.w_valid, 0);
        step();
        slv_req.aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slv_req.w.data = 32'h1000 + i;
            slv_req.w.last = (i == 3);
            @(negedge clk);
            chk("t1_wv", mst_req.w_valid, 1);
            chk("t1_last", mst_req.w.last, 32'(i == 3));
            chk("t1_data", mst_req.w.data, 32'h1000 + i);
            step();
        end
        @(negedge clk);
        chk("t1_err", err, 0);
        chk("t1_drained", mst_req.w_valid, 0);
        step();
        slv_req.w_valid = 1'b0;

        // W presented before its AW
        slv_req.w_valid = 1'b1;
        slv_req.w.data  = 32'hcafebabe;
        slv_req.w.last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_w_held", mst_req.w_valid, 0);
            chk("t2_wr_held", slv_resp.w_ready, 0);
            step();
        end
        slv_req.aw_valid = 1'b1;
        slv_req.aw.len   = 8'd0;
        slv_req.aw.id    = 4'h2;
        @(negedge clk);
        chk("t2_aw_fwd", mst_req.aw_valid, 1);
        chk("t2_w_same_cyc", mst_req.w_valid, 0);
        step();
        slv_req.aw_valid = 1'b0;
        @(negedge clk);
        chk("t2_wv", mst_req.w_valid, 1);
        chk("t2_last", mst_req.w.last, 1);
        chk("t2_data", mst_req.w.data, 32'hcafebabe);
        chk("t2_wr", slv_resp.w_ready, 1);
        step();
        slv_req.w_valid = 1'b0;

        // FIFO full with W withheld
        hs = 0;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.len   = 8'd0;
        for (int c = 0; c < 8; c++) begin
            slv_req.aw.id = 4'(hs);
            @(negedge clk);
            if (slv_resp.aw_ready) hs++;
            step();
        end
        chk("t3_hs", hs, 4);
        slv_req.w_valid = 1'b1;
        slv_req.w.last  = 1'b1;
        slv_req.w.data  = 32'h3;
        @(negedge clk);
        chk("t3_wr", slv_resp.w_ready, 1);
        chk("t3_last", mst_req.w.last, 1);
        chk("t3_full_pop", slv_resp.aw_ready, 0);
        chk("t3_full_awv", mst_req.aw_valid, 0);
        step();
        slv_req.w_valid = 1'b0;
        @(negedge clk);
        chk("t3_aw_after", slv_resp.aw_ready, 1);
        step();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_drain_wr", slv_resp.w_ready, 1);
            chk("t3_drain_last", mst_req.w.last, 1);
            step();
        end
        @(negedge clk);
        chk("t3_empty", mst_req.w_valid, 0);
        step();
        slv_req.w_valid = 1'b0;

        // upstream last disagrees with len=1
        slv_req.aw_valid = 1'b1;
        slv_req.aw.len   = 8'd1;
        step();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b1;
        slv_req.w.last   = 1'b1;
        @(negedge clk);
        chk("t4_last_b1", mst_req.w.last, 0);
        chk("t4_err_pre", err, 0);
        step();
        @(negedge clk);
        chk("t4_err_b1", err, 1);
        chk("t4_last_b2", mst_req.w.last, 1);
        step();
        slv_req.w_valid = 1'b0;
        @(negedge clk);
        chk("t4_err_sticky", err, 1);
        step();

        // asynchronous reset mid-burst of len=7
        slv_req.aw_valid = 1'b1;
        slv_req.aw.len   = 8'd7;
        step();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid  = 1'b1;
        slv_req.w.last   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            step();
        end
        #1;
        chk("t6_pre_wv", mst_req.w_valid, 1);
        chk("t6_pre_err", err, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wv", mst_req.w_valid, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_wr", slv_resp.w_ready, 0);
        slv_req.w_valid = 1'b0;
        step();
        rst_n = 1'b1;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.len   = 8'd0;
        slv_req.w_valid  = 1'b1;
        slv_req.w.last   = 1'b1;
        slv_req.w.data   = 32'h600d;
        @(negedge clk);
        chk("t6_fresh_blk", mst_req.w_valid, 0);
        step();
        slv_req.aw_valid = 1'b0;
        @(negedge clk);
        chk("t6_fresh_wv", mst_req.w_valid, 1);
        chk("t6_fresh_last", mst_req.w.last, 1);
        step();
        slv_req.w_valid = 1'b0;
        @(negedge clk);
        chk("t6_fresh_err", err, 0);
        step();

        // random stress with scoreboard
        for (int k = 0; k < NBursts; k++) begin
            plan[k]       = '0;
            plan[k].id    = 4'(k);
            plan[k].addr  = $urandom;
            plan[k].len   = 8'($urandom_range(0, 15));
            plan[k].size  = 3'd2;
            plan[k].burst = 2'd1;
        end
        slv_req  = '0;
        mst_resp = '0;
        mon_on   = 1'b1;
        aw_i = 0;
        w_k  = 0;
        w_b  = 0;
        b_got = 0;
        cyc   = 0;
        while (b_got < NBursts && cyc < MaxCyc) begin
            if (!slv_req.aw_valid && aw_i < NBursts &&
                $urandom_range(0, 1) == 1) begin
                slv_req.aw_valid = 1'b1;
                slv_req.aw       = plan[aw_i];
                exp_aw.push_back(plan[aw_i]);
                exp_b.push_back(plan[aw_i].id);
            end
            if (!slv_req.w_valid && w_k < NBursts &&
                $urandom_range(0, 2) != 0) begin
                slv_req.w_valid = 1'b1;
                slv_req.w.data  = $urandom;
                slv_req.w.strb  = 4'($urandom);
                slv_req.w.last  = (w_b == int'(plan[w_k].len));
                slv_req.w.user  = 1'b0;
                exp_w.push_back('{slv_req.w.data, slv_req.w.strb,
                                  slv_req.w.last, w_k});
            end
            slv_req.b_ready   = ($urandom_range(0, 1) == 1);
            mst_resp.aw_ready = ($urandom_range(0, 1) == 1);
            mst_resp.w_ready  = ($urandom_range(0, 3) != 0);
            if (!mst_resp.b_valid && s_bq.size() > 0 &&
                $urandom_range(0, 1) == 1) begin
                mst_resp.b_valid = 1'b1;
                mst_resp.b.id    = s_bq[0];
                mst_resp.b.resp  = 2'b00;
            end
            @(negedge clk);
            s_aw     = slv_req.aw_valid && slv_resp.aw_ready;
            s_w      = slv_req.w_valid && slv_resp.w_ready;
            s_wl     = slv_req.w.last;
            s_maw    = mst_req.aw_valid && mst_resp.aw_ready;
            s_maw_id = mst_req.aw.id;
            s_mwl    = mst_req.w_valid && mst_resp.w_ready && mst_req.w.last;
            s_b      = mst_resp.b_valid && mst_req.b_ready;
            step();
            cyc++;
            if (s_aw) begin
                slv_req.aw_valid = 1'b0;
                aw_i++;
            end
            if (s_w) begin
                slv_req.w_valid = 1'b0;
                if (s_wl) begin
                    w_k++;
                    w_b = 0;
                end else begin
                    w_b++;
                end
            end
            if (s_maw) s_ids.push_back(s_maw_id);
            if (s_mwl && s_ids.size() > 0) s_bq.push_back(s_ids.pop_front());
            if (s_b) begin
                mst_resp.b_valid = 1'b0;
                if (s_bq.size() > 0) void'(s_bq.pop_front());
                b_got++;
            end
        end
        chk("rnd_b_count", b_got, NBursts);
        slv_req.aw_valid  = 1'b0;
        slv_req.w_valid   = 1'b0;
        mst_resp.b_valid  = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("rnd_aw_count", aw_hs_seen, NBursts);
        chk("rnd_w_left", exp_w.size(), 0);
        chk("rnd_aw_left", exp_aw.size(), 0);
        chk("rnd_b_left", exp_b.size(), 0);
        chk("rnd_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_aw_before_w.md
Name: axi_aw_before_w

Overview:
- Write-channel ordering stage placed directly downstream of axi_delayer, in front of slaves that need each AW before any of its W beats.
- Forwards AW and records burst lengths.
- Releases W beats only for bursts whose AW has already completed its handshake downstream.
- Regenerates w.last from the recorded length.
- AR, R and B pass through combinationally.

Parameters:
- MaxWTxns, 4, depth of the outstanding-burst FIFO (AWs accepted downstream whose W burst is not yet complete); must be >= 1.
- req_t, logic, AXI request struct type (axi/typedef.svh).
- resp_t, logic, AXI response struct type (axi/typedef.svh).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- slv_req_i  in  req_t  request from upstream (delayer mst side).
- slv_resp_o  out  resp_t  response to upstream.
- mst_req_o  out  req_t  request to downstream slave.
- mst_resp_i  in  resp_t  response from downstream slave.
- err_o  out  1  sticky flag: upstream w.last disagreed with the recorded length.

Behaviour:
- Reset: FIFO empty, beat counter 0, err_o 0, mst aw_valid 0, mst w_valid 0.
- AW path:
  - mst aw fields = slv aw fields.
  - mst aw_valid = slv aw_valid & !fifo_full.
  - slv aw_ready = mst aw_ready & !fifo_full.
  - On the downstream AW handshake, aw.len is pushed into the FIFO. Zero latency; no AW register.
- FIFO full: AW is held off. This holds even when a W-last pop occurs in the same cycle. No pop-to-push combinational path; the AW is accepted the following cycle.
- W path:
  - mst w_valid = slv w_valid & !fifo_empty.
  - slv w_ready = mst w_ready & !fifo_empty.
  - W beats arriving before their AW wait; they are never dropped.
- FIFO empty: W is blocked. A push in cycle N makes W eligible from cycle N+1 at the earliest (registered FIFO output, no fall-through).
- Beat counter:
  - Type axi_pkg::len_t, width 8; increments on each downstream W handshake.
  - mst w.last = (beat_cnt == fifo_head_len).
  - On a last handshake: counter clears to 0 and the FIFO pops.
  - len=0: the first beat is last.
  - len=255: the counter reaches 255 and clears, with no overflow.
- All other mst w fields (data, strb, user) pass through.
- Error: on any downstream W handshake where slv w.last != generated last, err_o sets and stays 1 until reset. Forwarding is unaffected; the generated last wins.
- AR/R/B: pure wires, slv<->mst, including valid and ready.
- Simultaneous AW push and W last pop (FIFO not full): both take effect; occupancy is unchanged.
- Reset mid-operation: asynchronous clear of FIFO, counter and err_o. Outstanding state is discarded; the environment is reset with it.
- Protocol rules on the master side:
  - No valid deasserts without a handshake, except when caused by a full/empty transition.
  - Full only rises on an AW handshake and empty only rises on a W-last pop, both of which end the handshake. So no valid is ever withdrawn.
- Assertions (simulation only):
  - MaxWTxns >= 1.
  - No push when full.
  - No pop when empty.

Decomposition:
- No new package. Use axi_pkg::len_t and the AXI_TYPEDEF_* macros.
- One sub-module: fifo_v3 from common_cells, with FALL_THROUGH=0, DEPTH=MaxWTxns, dtype=len_t, storing burst lengths.
- Counter, gating and error flag live in the top module.

Test Plan:
- Single burst, ordered: AW len=3 then 4 W beats, downstream always ready -> first mst W handshake at least 1 cycle after AW handshake; mst w.last on beat 4 only; err_o=0.
- W before AW: upstream presents W beat (data 'hcafebabe) 5 cycles before AW len=0 -> mst w_valid=0 for those 5 cycles. After the AW handshake, the W forwards with last=1 the next cycle; slv w_ready=0 meanwhile.
- FIFO full: MaxWTxns=4, issue 5 AWs (len=0) with W withheld -> 4 AW handshakes, 5th AW stalls (slv aw_ready=0). Releasing one W lets the 5th AW complete one cycle after the pop.
- Length mismatch: AW len=1, upstream asserts w.last on beat 1 -> mst w.last=0 on beat 1 and 1 on beat 2; err_o=1 from beat 1 onward, sticky.
- Random stress: 200 AWs with random len 0..15 through axi_delayer (random stalls) into this block with a random-ready slave driver -> per burst, W beat count = len+1; mst AW/W ordering holds; 200 B responses with IDs matching AW order; err_o=0.
- Reset mid-burst: assert rst_ni low after beat 2 of a len=7 burst -> all mst valids 0 and err_o 0 immediately (asynchronous). After release, a fresh AW len=0 with 1 W completes normally.
